// File: rtl/signal_lamp_monitor_if.sv
// Bundle of the signals between traffic_light and the lamp monitor: the light
// code and clear request coming in, and the lamp drives and fault status going out.
interface signal_lamp_monitor_if;

  logic [1:0] light;
  logic       fault_clr;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic       walk;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] cycle_cnt;

  // Controller side: supplies the light code and clear, observes the lamps.
  modport master (
    output light,
    output fault_clr,
    input  lamp_red,
    input  lamp_yellow,
    input  lamp_green,
    input  walk,
    input  fault,
    input  fault_code,
    input  cycle_cnt
  );

  // Monitor side: consumes the light code and clear, drives the lamps.
  modport slave (
    input  light,
    input  fault_clr,
    output lamp_red,
    output lamp_yellow,
    output lamp_green,
    output walk,
    output fault,
    output fault_code,
    output cycle_cnt
  );

endinterface

// File: rtl/signal_lamp_monitor.sv
// Lamp driver and safety monitor sitting after traffic_light. It mirrors the
// light code onto the physical lamps and watches for illegal codes, out-of-order
// phases and phases that were held too briefly. Any violation latches a fault
// and forces flashing red until a clear arrives while the code is red.
module signal_lamp_monitor #(
  parameter int MIN_DWELL  = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  signal_lamp_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_SEQUENCE = 2'b10;
  localparam logic [1:0] FC_DWELL    = 2'b11;

  // The flash counter walks through one full on/off period, 2*FLASH_HALF steps.
  localparam int               FLASH_W    = $clog2(2 * FLASH_HALF);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_HALF - 1);
  localparam logic [FLASH_W-1:0] FLASH_ON   = FLASH_W'(FLASH_HALF);
  localparam logic [7:0]       DWELL_MIN  = 8'(MIN_DWELL);
  localparam logic [7:0]       DWELL_MAX  = 8'hFF;

  state_t             r_state;
  logic [1:0]         r_lightQ;
  logic [1:0]         r_lightPrev;
  logic [7:0]         r_dwell;
  logic [7:0]         r_dwellPrev;
  logic [FLASH_W-1:0] r_flashCnt;
  logic               r_lampRed;
  logic               r_lampYellow;
  logic               r_lampGreen;
  logic               r_walk;
  logic               r_fault;
  logic [1:0]         r_faultCode;
  logic [7:0]         r_cycleCnt;

  state_t             w_stateNext;
  logic [FLASH_W-1:0] w_flashNext;
  logic               w_lampRedNext;
  logic               w_lampYellowNext;
  logic               w_lampGreenNext;
  logic               w_walkNext;
  logic               w_faultNext;
  logic [1:0]         w_faultCodeNext;
  logic [7:0]         w_cycleCntNext;
  logic               w_change;
  logic               w_legalStep;
  logic               w_shortDwell;
  logic               w_redToGreen;

  // Sample the incoming code and keep one cycle of history; r_dwellPrev holds the
  // final dwell of the outgoing code on the cycle a change becomes visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lightQ    <= LIGHT_RED;
      r_lightPrev <= LIGHT_RED;
      r_dwell     <= 8'd0;
      r_dwellPrev <= 8'd0;
    end else begin
      r_lightQ    <= bus.light;
      r_lightPrev <= r_lightQ;
      r_dwellPrev <= r_dwell;
      if (bus.light != r_lightQ) begin
        r_dwell <= 8'd1;
      end else if (r_dwell != DWELL_MAX) begin
        r_dwell <= r_dwell + 8'd1;
      end
    end
  end

  // Classify the most recent code change against the legal phase ring R->G->Y->R.
  always_comb begin
    w_change     = (r_lightQ != r_lightPrev);
    w_redToGreen = (r_lightPrev == LIGHT_RED)    && (r_lightQ == LIGHT_GREEN);
    w_legalStep  = w_redToGreen ||
                   ((r_lightPrev == LIGHT_GREEN)  && (r_lightQ == LIGHT_YELLOW)) ||
                   ((r_lightPrev == LIGHT_YELLOW) && (r_lightQ == LIGHT_RED));
    w_shortDwell = (r_dwellPrev < DWELL_MIN);
  end

  // Next state plus the values every registered output takes on the same edge.
  always_comb begin
    w_stateNext      = r_state;
    w_faultCodeNext  = r_faultCode;
    w_cycleCntNext   = r_cycleCnt;
    w_flashNext      = '0;
    w_lampRedNext    = 1'b0;
    w_lampYellowNext = 1'b0;
    w_lampGreenNext  = 1'b0;
    w_walkNext       = 1'b0;
    w_faultNext      = 1'b0;

    unique case (r_state)
      ST_INIT: begin
        if (r_lightQ == LIGHT_RED) begin
          w_stateNext = ST_NORMAL;
        end else if (r_lightQ == LIGHT_ILLEGAL) begin
          w_stateNext     = ST_FAULT;
          w_faultCodeNext = FC_ILLEGAL;
        end
      end
      ST_NORMAL: begin
        if (w_change) begin
          if (r_lightQ == LIGHT_ILLEGAL) begin
            w_stateNext     = ST_FAULT;
            w_faultCodeNext = FC_ILLEGAL;
          end else if (!w_legalStep) begin
            w_stateNext     = ST_FAULT;
            w_faultCodeNext = FC_SEQUENCE;
          end else if (w_shortDwell) begin
            w_stateNext     = ST_FAULT;
            w_faultCodeNext = FC_DWELL;
          end else if (w_redToGreen) begin
            w_cycleCntNext = r_cycleCnt + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr && (r_lightQ == LIGHT_RED)) begin
          w_stateNext     = ST_INIT;
          w_faultCodeNext = FC_NONE;
        end else if (r_flashCnt == FLASH_LAST) begin
          w_flashNext = '0;
        end else begin
          w_flashNext = r_flashCnt + FLASH_W'(1);
        end
      end
      default: begin
        w_stateNext     = ST_INIT;
        w_faultCodeNext = FC_NONE;
      end
    endcase

    // Entering FAULT leaves the flash counter at zero so the first cycle is lit.
    unique case (w_stateNext)
      ST_INIT: begin
        w_lampRedNext = 1'b1;
      end
      ST_NORMAL: begin
        w_lampRedNext    = (r_lightQ == LIGHT_RED);
        w_lampGreenNext  = (r_lightQ == LIGHT_GREEN);
        w_lampYellowNext = (r_lightQ == LIGHT_YELLOW);
        w_walkNext       = (r_lightQ == LIGHT_RED);
      end
      ST_FAULT: begin
        w_faultNext   = 1'b1;
        w_lampRedNext = (w_flashNext < FLASH_ON);
      end
      default: begin
        w_lampRedNext = 1'b1;
      end
    endcase
  end

  // State, flash phase and all registered outputs; reset wins even mid-fault.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_flashCnt   <= '0;
      r_lampRed    <= 1'b1;
      r_lampYellow <= 1'b0;
      r_lampGreen  <= 1'b0;
      r_walk       <= 1'b0;
      r_fault      <= 1'b0;
      r_faultCode  <= FC_NONE;
      r_cycleCnt   <= 8'd0;
    end else begin
      r_state      <= w_stateNext;
      r_flashCnt   <= w_flashNext;
      r_lampRed    <= w_lampRedNext;
      r_lampYellow <= w_lampYellowNext;
      r_lampGreen  <= w_lampGreenNext;
      r_walk       <= w_walkNext;
      r_fault      <= w_faultNext;
      r_faultCode  <= w_faultCodeNext;
      r_cycleCnt   <= w_cycleCntNext;
    end
  end

  assign bus.lamp_red    = r_lampRed;
  assign bus.lamp_yellow = r_lampYellow;
  assign bus.lamp_green  = r_lampGreen;
  assign bus.walk        = r_walk;
  assign bus.fault       = r_fault;
  assign bus.fault_code  = r_faultCode;
  assign bus.cycle_cnt   = r_cycleCnt;

endmodule

// File: tb/tb_signal_lamp_monitor.sv
// Bench for signal_lamp_monitor: directed scenarios followed by a random phase,
// all compared every cycle against a history-based behavioural model.
module tb_signal_lamp_monitor;

  localparam int MIN_DWELL  = 2;
  localparam int FLASH_HALF = 4;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_ILL    = 2'b11;

  localparam int M_INIT   = 0;
  localparam int M_NORMAL = 1;
  localparam int M_FAULT  = 2;

  logic clk;
  logic reset;
  int   compareCount = 0;
  int   failCount    = 0;

  signal_lamp_monitor_if bus();

  signal_lamp_monitor #(
    .MIN_DWELL (MIN_DWELL),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every code sampled since reset, plus mode/fault bookkeeping.
  logic [1:0] hist[$];
  int         mMode;
  logic [1:0] mCode;
  int         mCnt;
  int         mAge;
  logic       expRed, expYellow, expGreen, expWalk, expFault;

  // Code sampled at position k of the history; before the first sample it is red.
  function automatic logic [1:0] codeAt(input int k);
    if (k < 0) return L_RED;
    return hist[k];
  endfunction

  // How many consecutive samples of hist[k] end at position k, capped at 255.
  function automatic int runEnding(input int k);
    int n;
    n = 0;
    if (k < 0) return 0;
    for (int j = k; j >= 0; j--) begin
      if (hist[j] != hist[k] || n == 255) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic isLegalStep(input logic [1:0] p, input logic [1:0] q);
    return (p == L_RED && q == L_GREEN) || (p == L_GREEN && q == L_YELLOW) ||
           (p == L_YELLOW && q == L_RED);
  endfunction

  function automatic logic [1:0] nextLegal(input logic [1:0] c);
    case (c)
      L_RED:    return L_GREEN;
      L_GREEN:  return L_YELLOW;
      default:  return L_RED;
    endcase
  endfunction

  task automatic modelReset();
    hist.delete();
    mMode = M_INIT; mCode = 2'b00; mCnt = 0; mAge = 0;
    expRed = 1'b1; expYellow = 1'b0; expGreen = 1'b0; expWalk = 1'b0; expFault = 1'b0;
  endtask

  // One clock edge: judge the code sampled on the previous edge, then record this one.
  task automatic modelStep(input logic [1:0] sampled, input logic clr);
    int         n;
    int         dprev;
    logic [1:0] q;
    logic [1:0] p;
    n     = hist.size();
    q     = codeAt(n - 1);
    p     = codeAt(n - 2);
    dprev = runEnding(n - 2);
    case (mMode)
      M_INIT: begin
        if (q == L_RED) mMode = M_NORMAL;
        else if (q == L_ILL) begin mMode = M_FAULT; mCode = 2'b01; mAge = 0; end
      end
      M_NORMAL: begin
        if (q != p) begin
          if (q == L_ILL) begin mMode = M_FAULT; mCode = 2'b01; mAge = 0; end
          else if (!isLegalStep(p, q)) begin mMode = M_FAULT; mCode = 2'b10; mAge = 0; end
          else if (dprev < MIN_DWELL) begin mMode = M_FAULT; mCode = 2'b11; mAge = 0; end
          else if (p == L_RED && q == L_GREEN) mCnt = (mCnt + 1) % 256;
        end
      end
      default: begin
        if (clr && q == L_RED) begin mMode = M_INIT; mCode = 2'b00; end
        else mAge++;
      end
    endcase
    expRed = 1'b0; expYellow = 1'b0; expGreen = 1'b0; expWalk = 1'b0; expFault = 1'b0;
    case (mMode)
      M_INIT:   expRed = 1'b1;
      M_NORMAL: begin
        expRed    = (q == L_RED);
        expGreen  = (q == L_GREEN);
        expYellow = (q == L_YELLOW);
        expWalk   = (q == L_RED);
      end
      default: begin
        expFault = 1'b1;
        expRed   = (((mAge / FLASH_HALF) % 2) == 0);
      end
    endcase
    hist.push_back(sampled);
  endtask

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's current expectation.
  task automatic checkOutput();
    checkValue("lamp_red",    8'(bus.lamp_red),    8'(expRed));
    checkValue("lamp_yellow", 8'(bus.lamp_yellow), 8'(expYellow));
    checkValue("lamp_green",  8'(bus.lamp_green),  8'(expGreen));
    checkValue("walk",        8'(bus.walk),        8'(expWalk));
    checkValue("fault",       8'(bus.fault),       8'(expFault));
    checkValue("fault_code",  8'(bus.fault_code),  8'(mCode));
    checkValue("cycle_cnt",   bus.cycle_cnt,       8'(mCnt));
  endtask

  // Drive one cycle of inputs while the clock is low, check 1 unit after the edge.
  task automatic applyStimulus(input logic [1:0] l, input logic c);
    bus.light     = l;
    bus.fault_clr = c;
    @(posedge clk);
    modelStep(l, c);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    @(posedge clk);
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic holdLight(input logic [1:0] l, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(l, 1'b0);
  endtask

  // Directed scenarios, then the 256-cycle wrap, then randomized traffic.
  initial begin
    logic [7:0] pattern;
    logic [1:0] curLight;
    int         r;
    logic       clr;

    reset         = 1'b0;
    bus.light     = L_RED;
    bus.fault_clr = 1'b0;
    applyReset();

    // Normal sequence R x5, G x5, Y x5, R.
    holdLight(L_RED, 5); holdLight(L_GREEN, 5); holdLight(L_YELLOW, 5); holdLight(L_RED, 2);
    checkValue("seq_cycle_cnt", bus.cycle_cnt, 8'd1);
    checkValue("seq_fault", 8'(bus.fault), 8'd0);

    // Illegal code for one cycle, then watch the flash pattern.
    applyStimulus(L_ILL, 1'b0);
    pattern = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(L_RED, 1'b0);
      pattern = {pattern[6:0], bus.lamp_red};
    end
    checkValue("flash_pattern", pattern, 8'hF0);
    checkValue("illegal_code", 8'(bus.fault_code), 8'd1);

    // Clear back to NORMAL, then green-to-red is a sequence fault.
    applyStimulus(L_RED, 1'b1); holdLight(L_RED, 3);
    holdLight(L_GREEN, 5); applyStimulus(L_RED, 1'b0);
    holdLight(L_GREEN, 1); holdLight(L_YELLOW, 3);
    checkValue("sequence_code_held", 8'(bus.fault_code), 8'd2);

    // Clear, then a green held for one cycle is a dwell fault.
    applyStimulus(L_RED, 1'b0); applyStimulus(L_RED, 1'b1); holdLight(L_RED, 2);
    holdLight(L_RED, 2); holdLight(L_GREEN, 1); holdLight(L_YELLOW, 3);
    checkValue("dwell_code", 8'(bus.fault_code), 8'd3);
    checkValue("dwell_cycle_cnt", bus.cycle_cnt, 8'd3);

    // Clear request while green is ignored; while red it clears.
    applyStimulus(L_GREEN, 1'b0); applyStimulus(L_GREEN, 1'b1);
    checkValue("clr_on_green_fault", 8'(bus.fault), 8'd1);
    applyStimulus(L_RED, 1'b0); applyStimulus(L_RED, 1'b1);
    checkValue("clr_on_red_fault", 8'(bus.fault), 8'd0);
    checkValue("clr_on_red_code", 8'(bus.fault_code), 8'd0);
    checkValue("clr_on_red_lamp", 8'(bus.lamp_red), 8'd1);
    holdLight(L_RED, 2); holdLight(L_GREEN, 2); holdLight(L_YELLOW, 2); holdLight(L_RED, 2);
    checkValue("clr_then_normal_fault", 8'(bus.fault), 8'd0);
    checkValue("clr_then_cycle_cnt", bus.cycle_cnt, 8'd4);

    // 256 legal cycles from reset wrap the counter back to zero.
    applyReset();
    for (int i = 0; i < 256; i++) begin
      holdLight(L_RED, 2); holdLight(L_GREEN, 2); holdLight(L_YELLOW, 2);
    end
    holdLight(L_RED, 2);
    checkValue("wrap_cycle_cnt", bus.cycle_cnt, 8'd0);
    holdLight(L_GREEN, 2); holdLight(L_YELLOW, 1);
    checkValue("after_wrap_cnt", bus.cycle_cnt, 8'd1);

    // Reset in the middle of a fault restores every reset value.
    applyStimulus(L_ILL, 1'b0); holdLight(L_GREEN, 3);
    checkValue("pre_reset_fault", 8'(bus.fault), 8'd1);
    applyReset();
    checkValue("rst_lamp_red", 8'(bus.lamp_red), 8'd1);
    checkValue("rst_fault", 8'(bus.fault), 8'd0);
    checkValue("rst_code", 8'(bus.fault_code), 8'd0);
    checkValue("rst_cycle_cnt", bus.cycle_cnt, 8'd0);
    checkValue("rst_walk", 8'(bus.walk), 8'd0);

    // Random traffic: mostly holds and legal steps, occasional wild codes and clears.
    curLight = L_RED;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r >= 6 && r <= 8) curLight = nextLegal(curLight);
      else if (r == 9) curLight = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 7) == 0);
      applyStimulus(curLight, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
